// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, opcode fields, FSM encoding and branch offset helper for the IF stage
package fetch_stage_pkg;
  localparam int IC_WIDTH = 32;
  localparam int PC_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int BXX_IMM_MSB = 22;
  localparam logic [OP_MSB-OP_LSB:0] OP_BXX = 5'b10100;
  typedef enum logic {S_REQ = 1'b0, S_DISCARD = 1'b1} fetch_state_e;
  function automatic logic [PC_WIDTH-1:0] bxx_offset(input logic [BXX_IMM_MSB:0] imm);
    return {{(PC_WIDTH-BXX_IMM_MSB-3){imm[BXX_IMM_MSB]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_static_bpred.sv
// static_bpred: backward-taken prediction for BXX; pred_target_o is the next fetch PC either way
module static_bpred
  import fetch_stage_pkg::*;
(
  input  logic [INST_WIDTH-1:0] ir_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  output logic                  pred_taken_o,
  output logic [PC_WIDTH-1:0]   pred_target_o
);
  logic unused_ok;
  assign unused_ok = ^ir_i[OP_LSB-1:BXX_IMM_MSB+1];
  always_comb begin
    pred_taken_o  = ir_i[OP_MSB:OP_LSB] == OP_BXX && ir_i[BXX_IMM_MSB];
    pred_target_o = pred_taken_o ? pc_i + bxx_offset(ir_i[BXX_IMM_MSB:0]) : pc_i + 32'd4;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage holding PC/IC, a request FSM to instruction memory and the IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [IC_WIDTH-1:0] IC_RESET = 32'd0
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   iTarget,
  output logic [PC_WIDTH-1:0]   oIMemAddr,
  output logic                  oIMemReq,
  input  logic [INST_WIDTH-1:0] iIMemData,
  input  logic                  iIMemAck,
  output logic [IC_WIDTH-1:0]   oIC,
  output logic                  oPPCCB,
  output logic [PC_WIDTH-1:0]   oPC,
  output logic                  oValid,
  output logic [INST_WIDTH-1:0] oIR
);
  fetch_state_e state_q, state_d;
  logic req_q, valid_q, valid_d, ppccb_q, ppccb_d, accept, pred_taken;
  logic [PC_WIDTH-1:0] pc_q, pc_d, opc_q, opc_d, pred_target;
  logic [IC_WIDTH-1:0] ic_q, ic_d, oic_q, oic_d;
  logic [INST_WIDTH-1:0] ir_q, ir_d;
  static_bpred u_bpred (
    .ir_i(iIMemData),
    .pc_i(pc_q),
    .pred_taken_o(pred_taken),
    .pred_target_o(pred_target)
  );
  // a flush with the request still unanswered must swallow the stale response
  always_comb begin
    accept  = iIMemAck && req_q && state_q == S_REQ && !stall && !flush;
    pc_d    = flush ? iTarget : accept ? pred_target : pc_q;
    ic_d    = accept ? ic_q + 32'd1 : ic_q;
    ir_d    = accept ? iIMemData : ir_q;
    opc_d   = accept ? pc_q : opc_q;
    oic_d   = accept ? ic_q : oic_q;
    valid_d = (stall && !flush) ? valid_q : accept;
    ppccb_d = flush ? 1'b0 : accept ? pred_taken : ppccb_q;
    state_d = flush ? ((req_q && !iIMemAck) ? S_DISCARD : S_REQ)
            : (state_q == S_DISCARD && iIMemAck) ? S_REQ : state_q;
  end
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      ic_q    <= IC_RESET;
      ir_q    <= '0;
      opc_q   <= '0;
      oic_q   <= '0;
      valid_q <= 1'b0;
      ppccb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= 1'b1;
      pc_q    <= pc_d;
      ic_q    <= ic_d;
      ir_q    <= ir_d;
      opc_q   <= opc_d;
      oic_q   <= oic_d;
      valid_q <= valid_d;
      ppccb_q <= ppccb_d;
    end
  end
  assign oIMemAddr = pc_q;
  assign oIMemReq  = req_q;
  assign oIC       = oic_q;
  assign oPPCCB    = ppccb_q;
  assign oPC       = opc_q;
  assign oValid    = valid_q;
  assign oIR       = ir_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard queue checked by an independent output monitor
module tb_fetch_stage;
  logic Clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, iIMemAck = 1'b0;
  logic [31:0] iTarget = '0, iIMemData = '0;
  logic [31:0] oIMemAddr, oIC, oPC, oIR;
  logic oIMemReq, oPPCCB, oValid;
  logic ack_en = 1'b1, stale = 1'b0, stall_e = 1'b0;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [31:0] pc; logic [31:0] ic; logic [31:0] ir; logic ppccb;} exp_t;
  exp_t exp_q[$];
  exp_t m_e;
  logic [31:0] prog [logic [31:0]];
  localparam logic [31:0] BXX_T = 32'hA07F_FFFE;
  localparam logic [31:0] BXX_N = 32'hA000_0002;

  fetch_stage dut (
    .Clk(Clk), .reset(reset), .stall(stall), .flush(flush), .iTarget(iTarget),
    .oIMemAddr(oIMemAddr), .oIMemReq(oIMemReq), .iIMemData(iIMemData), .iIMemAck(iIMemAck),
    .oIC(oIC), .oPPCCB(oPPCCB), .oPC(oPC), .oValid(oValid), .oIR(oIR)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] add_w(input logic [31:0] a);
    return {5'h01, a[26:0]};
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return prog.exists(a) ? prog[a] : add_w(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ic, input logic [31:0] ir, input logic p);
    exp_t e;
    e.pc = pc;
    e.ic = ic;
    e.ir = ir;
    e.ppccb = p;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " oValid"}, {31'b0, oValid}, 32'd0);
    check({tag, " oIR"}, oIR, 32'd0);
    check({tag, " oPC"}, oPC, 32'd0);
    check({tag, " oIC"}, oIC, 32'd0);
    check({tag, " oPPCCB"}, {31'b0, oPPCCB}, 32'd0);
    check({tag, " oIMemReq"}, {31'b0, oIMemReq}, 32'd0);
    check({tag, " oIMemAddr"}, oIMemAddr, 32'd0);
  endtask

  // single-cycle memory: answers whatever address is presented while ack_en is high
  always @(negedge Clk) begin
    #2;
    iIMemData = stale ? 32'hDEAD_BEEF : word(oIMemAddr);
    iIMemAck  = oIMemReq && ack_en;
  end

  always @(posedge Clk) stall_e <= stall;

  always @(negedge Clk) begin
    if (!reset && oValid && !stall_e) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected output: oPC %h oIC %h with empty scoreboard", oPC, oIC);
      end else begin
        m_e = exp_q.pop_front();
        check("mon oPC", oPC, m_e.pc);
        check("mon oIC", oIC, m_e.ic);
        check("mon oIR", oIR, m_e.ir);
        check("mon oPPCCB", {31'b0, oPPCCB}, {31'b0, m_e.ppccb});
      end
    end
  end

  initial begin
    prog[32'h40] = BXX_T;
    tick(2);
    check_reset_vals("reset");
    for (int k = 0; k <= 16; k++) push(32'(4 * k), 32'(k), k == 16 ? BXX_T : add_w(32'(4 * k)), k == 16);
    push(32'h38, 32'd17, add_w(32'h38), 1'b0);
    push(32'h3C, 32'd18, add_w(32'h3C), 1'b0);
    push(32'h40, 32'd19, BXX_N, 1'b0);
    push(32'h44, 32'd20, add_w(32'h44), 1'b0);
    tick(1);
    reset = 1'b0;
    tick(18);
    prog[32'h40] = BXX_N;
    tick(4);
    push(32'h48, 32'd21, add_w(32'h48), 1'b0);
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("wait oValid", {31'b0, oValid}, 32'd0);
      check("wait oIMemAddr", oIMemAddr, 32'h48);
    end
    ack_en = 1'b1;
    tick(1);
    push(32'h4C, 32'd22, add_w(32'h4C), 1'b0);
    push(32'h50, 32'd23, add_w(32'h50), 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("stall oPC", oPC, 32'h48);
      check("stall oIC", oIC, 32'd21);
      check("stall oIR", oIR, add_w(32'h48));
      check("stall oValid", {31'b0, oValid}, 32'd1);
    end
    stall = 1'b0;
    tick(2);
    ack_en = 1'b0;
    tick(1);
    push(32'h100, 32'd24, add_w(32'h100), 1'b0);
    flush = 1'b1;
    iTarget = 32'h100;
    tick(1);
    check("flush oValid", {31'b0, oValid}, 32'd0);
    flush = 1'b0;
    ack_en = 1'b1;
    stale = 1'b1;
    tick(1);
    check("discard oValid", {31'b0, oValid}, 32'd0);
    check("discard oIMemAddr", oIMemAddr, 32'h100);
    stale = 1'b0;
    tick(1);
    push(32'h200, 32'd25, add_w(32'h200), 1'b0);
    flush = 1'b1;
    stall = 1'b1;
    iTarget = 32'h200;
    tick(1);
    check("flush+stall oValid", {31'b0, oValid}, 32'd0);
    check("flush+stall oPPCCB", {31'b0, oPPCCB}, 32'd0);
    check("flush+stall oIMemAddr", oIMemAddr, 32'h200);
    check("flush+stall oPC", oPC, 32'h100);
    check("flush+stall oIC", oIC, 32'd24);
    flush = 1'b0;
    stall = 1'b0;
    tick(1);
    ack_en = 1'b0;
    tick(1);
    #2;
    check("drain before reset", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_vals("async reset");
    push(32'h0, 32'd0, add_w(32'h0), 1'b0);
    push(32'h4, 32'd1, add_w(32'h4), 1'b0);
    tick(1);
    reset = 1'b0;
    ack_en = 1'b1;
    tick(1);
    check("restart oIMemReq", {31'b0, oIMemReq}, 32'd1);
    tick(2);
    ack_en = 1'b0;
    tick(3);
    check("final drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
